// File: rtl/mips_single_cycle_core_pkg.sv
// Shared encodings for the single-cycle MIPS core: opcodes, R-type function
// codes, ALU control codes and the immediate sign-extension helper.
package mips_single_cycle_core_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111
  } alu_ctrl_e;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_control.sv
// Main decoder plus ALU control: maps opcode/funct to datapath selects.
// Any unsupported encoding decodes to a NOP (no writes, PC+4).
module mips_control
  import mips_single_cycle_core_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic       reg_dst_o,
  output logic       reg_wr_o,
  output logic       alu_src_o,
  output logic       mem_wr_o,
  output logic       mem_to_reg_o,
  output logic       branch_o,
  output logic       jump_o,
  output alu_ctrl_e  alu_ctrl_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    reg_dst_o    = 1'b0;
    reg_wr_o     = 1'b0;
    alu_src_o    = 1'b0;
    mem_wr_o     = 1'b0;
    mem_to_reg_o = 1'b0;
    branch_o     = 1'b0;
    jump_o       = 1'b0;
    alu_ctrl_o   = ALU_ADD;
    case (op_i)
      OP_RTYPE: begin
        reg_dst_o = 1'b1;
        reg_wr_o  = 1'b1;
        case (funct_i)
          FN_ADD:  alu_ctrl_o = ALU_ADD;
          FN_SUB:  alu_ctrl_o = ALU_SUB;
          FN_AND:  alu_ctrl_o = ALU_AND;
          FN_OR:   alu_ctrl_o = ALU_OR;
          FN_SLT:  alu_ctrl_o = ALU_SLT;
          default: begin
            reg_dst_o = 1'b0;
            reg_wr_o  = 1'b0;
          end
        endcase
      end
      OP_LW: begin
        reg_wr_o     = 1'b1;
        alu_src_o    = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      OP_SW: begin
        alu_src_o = 1'b1;
        mem_wr_o  = 1'b1;
      end
      OP_BEQ: begin
        branch_o   = 1'b1;
        alu_ctrl_o = ALU_SUB;
      end
      OP_ADDI: begin
        reg_wr_o  = 1'b1;
        alu_src_o = 1'b1;
      end
      OP_J:    jump_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mem.sv
// Instruction ROM and data RAM: word-addressed, combinational read, and the
// data RAM writes on the rising edge.
module mips_instr_mem #(
  parameter int WORDS = 256,
  parameter int AW    = 8
) (
  input  logic          clk_i,
  input  logic          load_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [31:0]   load_data_i,
  input  logic [AW-1:0] addr_i,
  output logic [31:0]   instr_o
);

  logic [31:0] memi [0:WORDS-1];

  // Load port is tied off in the core; contents are preloaded before reset release.
  always_ff @(posedge clk_i) begin
    if (load_i) memi[load_addr_i] <= load_data_i;
  end

  assign instr_o = memi[addr_i];

endmodule

module mips_data_mem #(
  parameter int WORDS = 256,
  parameter int AW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wd_i,
  output logic [31:0]   rd_o
);

  logic [31:0] memd [0:WORDS-1];

  // NOTE: storage has no reset so preloaded contents survive Rst; only the PC resets.
  // NOTE: non-blocking write, so this cycle's combinational read still sees the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) memd[addr_i] <= wd_i;
  end

  assign rd_o = memd[addr_i];

endmodule

// File: rtl/mips_reg_file.sv
// 32x32 register file, two combinational read ports and one write port.
// $0 reads as zero and writes to it are dropped.
module mips_reg_file (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);

  logic [31:0] memr [0:31];

  always_ff @(posedge clk_i) begin
    if (we_i && (wa_i != 5'd0)) memr[wa_i] <= wd_i;
  end

  assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : memr[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : memr[ra2_i];

endmodule

// File: rtl/mips_single_cycle_core.sv
// Single-cycle MIPS core: fetch, decode, execute, memory and write-back all
// complete in one clock; only the PC (and memory/register writes) are clocked.
module mips_single_cycle_core
  import mips_single_cycle_core_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic [31:0] AluResult,
  output logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [4:0]  WriteReg,
  output logic [31:0] PcOut
);

  localparam int IMEM_AW = $clog2(IMEM_WORDS);
  localparam int DMEM_AW = $clog2(DMEM_WORDS);

  logic [31:0] pc_q, pc_d, pc_plus4, branch_target, jump_target;
  logic [31:0] InstrOut, imm_ext, rd1, rd2, alu_b;
  logic        RegDst, RegWr, AluSrc, Zero, PcSrc, Jump;
  logic        mem_wr, mem_to_reg, branch;
  alu_ctrl_e   AluCtrl;

  mips_instr_mem #(.WORDS(IMEM_WORDS), .AW(IMEM_AW)) INSTR_MEM (
    .clk_i       (Clk),
    .load_i      (1'b0),
    .load_addr_i ('0),
    .load_data_i ('0),
    .addr_i      (pc_q[IMEM_AW+1:2]),
    .instr_o     (InstrOut)
  );

  mips_control CONTROL (
    .op_i         (InstrOut[31:26]),
    .funct_i      (InstrOut[5:0]),
    .reg_dst_o    (RegDst),
    .reg_wr_o     (RegWr),
    .alu_src_o    (AluSrc),
    .mem_wr_o     (mem_wr),
    .mem_to_reg_o (mem_to_reg),
    .branch_o     (branch),
    .jump_o       (Jump),
    .alu_ctrl_o   (AluCtrl)
  );

  mips_reg_file REG_FILE (
    .clk_i (Clk),
    .we_i  (RegWr),
    .ra1_i (InstrOut[25:21]),
    .ra2_i (InstrOut[20:16]),
    .wa_i  (WriteReg),
    .wd_i  (WriteData),
    .rd1_o (rd1),
    .rd2_o (rd2)
  );

  assign imm_ext = sign_ext16(InstrOut[15:0]);
  assign alu_b   = AluSrc ? imm_ext : rd2;

  always_comb begin
    case (AluCtrl)
      ALU_AND: AluResult = rd1 & alu_b;
      ALU_OR:  AluResult = rd1 | alu_b;
      ALU_ADD: AluResult = rd1 + alu_b;
      ALU_SUB: AluResult = rd1 - alu_b;
      ALU_SLT: AluResult = ($signed(rd1) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: AluResult = 32'd0;
    endcase
  end

  assign Zero = (AluResult == 32'd0);

  mips_data_mem #(.WORDS(DMEM_WORDS), .AW(DMEM_AW)) DATA_MEM (
    .clk_i  (Clk),
    .we_i   (mem_wr),
    .addr_i (AluResult[DMEM_AW+1:2]),
    .wd_i   (rd2),
    .rd_o   (ReadData)
  );

  assign WriteReg  = RegDst ? InstrOut[15:11] : InstrOut[20:16];
  assign WriteData = mem_to_reg ? ReadData : AluResult;

  // Jump outranks a taken branch; everything else falls through to PC+4.
  assign pc_plus4      = pc_q + 32'd4;
  assign branch_target = pc_plus4 + {imm_ext[29:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], InstrOut[25:0], 2'b00};
  assign PcSrc         = branch & Zero;
  assign pc_d          = Jump ? jump_target : (PcSrc ? branch_target : pc_plus4);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) pc_q <= 32'd0;
    else      pc_q <= pc_d;
  end

  assign PcOut = pc_q;

endmodule

// File: tb/tb_mips_single_cycle_core.sv
// Bench for mips_single_cycle_core: a directed prologue plus random program,
// executed by an instruction-level reference model and compared every cycle.
module tb_mips_single_cycle_core;

  localparam int NCYC = 200;

  localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
  localparam logic [5:0] T_BEQ = 6'b000100, T_ADDI = 6'b001000, T_J = 6'b000010;
  localparam logic [5:0] T_ORI = 6'b001101;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010, F_XOR = 6'b100110;

  logic        Clk, Rst;
  logic [31:0] AluResult, WriteData, ReadData, PcOut;
  logic [4:0]  WriteReg;

  mips_single_cycle_core #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .AluResult (AluResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .WriteReg  (WriteReg),
    .PcOut     (PcOut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] pc, alu, wd, rdata;
    logic [4:0]  wreg;
    bit regwr, regdst, alusrc, zero, pcsrc, jump, chk_alu, chk_mem;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks, n_errors;
  logic [31:0] cur_pc;
  logic [31:0] m_reg  [32];
  logic [31:0] m_dmem [256];
  logic [31:0] m_imem [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (pc %h): got %h expected %h", name, cur_pc, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {T_R, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Architectural reference: executes one instruction on the model state.
  task automatic model_step(inout logic [31:0] pc, output exp_t e);
    logic [31:0] ins, a, b, se, res, addr, npc;
    logic [4:0]  rs, rt, rd;
    int          idx;
    ins = m_imem[(pc >> 2) & 32'hFF];
    rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    a = m_reg[rs]; b = m_reg[rt];
    se = {{16{ins[15]}}, ins[15:0]};
    npc = pc + 32'd4;
    res = 32'd0;
    e = '{default: 0};
    e.pc = pc;
    case (ins[31:26])
      T_R: begin
        e.chk_alu = 1;
        case (ins[5:0])
          F_ADD:   res = a + b;
          F_SUB:   res = a - b;
          F_AND:   res = a & b;
          F_OR:    res = a | b;
          F_SLT:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: e.chk_alu = 0;
        endcase
        if (e.chk_alu) begin
          e.regwr = 1; e.regdst = 1; e.wreg = rd; e.wd = res;
          if (rd != 0) m_reg[rd] = res;
        end
      end
      T_ADDI: begin
        res = a + se;
        e.chk_alu = 1; e.regwr = 1; e.alusrc = 1; e.wreg = rt; e.wd = res;
        if (rt != 0) m_reg[rt] = res;
      end
      T_LW: begin
        res = a + se; idx = int'((res >> 2) & 32'hFF);
        e.rdata = m_dmem[idx];
        e.chk_alu = 1; e.chk_mem = 1; e.regwr = 1; e.alusrc = 1; e.wreg = rt; e.wd = e.rdata;
        if (rt != 0) m_reg[rt] = e.rdata;
      end
      T_SW: begin
        res = a + se; idx = int'((res >> 2) & 32'hFF);
        e.rdata = m_dmem[idx];
        e.chk_alu = 1; e.chk_mem = 1; e.alusrc = 1;
        m_dmem[idx] = b;
      end
      T_BEQ: begin
        res = a - b;
        e.chk_alu = 1;
        if (a == b) begin
          e.pcsrc = 1;
          npc = npc + (se << 2);
        end
      end
      T_J: begin
        e.jump = 1;
        npc = {npc[31:28], ins[25:0], 2'b00};
      end
      default: ;
    endcase
    e.alu  = res;
    e.zero = (res == 32'd0);
    pc = npc;
  endtask

  // Monitor: one expected record per executed instruction, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge Clk);
      if (Rst && exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        cur_pc = e.pc;
        check("pc", PcOut, e.pc);
        check("reg_wr", {31'd0, dut.RegWr}, {31'd0, e.regwr});
        check("jump", {31'd0, dut.Jump}, {31'd0, e.jump});
        check("pc_src", {31'd0, dut.PcSrc}, {31'd0, e.pcsrc});
        if (e.chk_alu) begin
          check("alu_result", AluResult, e.alu);
          check("zero", {31'd0, dut.Zero}, {31'd0, e.zero});
          check("alu_src", {31'd0, dut.AluSrc}, {31'd0, e.alusrc});
        end
        if (e.regwr) begin
          check("write_reg", {27'd0, WriteReg}, {27'd0, e.wreg});
          check("write_data", WriteData, e.wd);
          check("reg_dst", {31'd0, dut.RegDst}, {31'd0, e.regdst});
        end
        if (e.chk_mem) check("read_data", ReadData, e.rdata);
      end
    end
  end

  initial begin
    logic [31:0] pc;
    exp_t        e;
    n_checks = 0; n_errors = 0; cur_pc = 32'd0;
    Rst = 1'b0;

    m_reg[0] = 32'd0;
    for (int i = 1; i < 32; i++) m_reg[i] = $urandom;
    m_reg[8] = 32'd7; m_reg[9] = 32'd7;
    for (int i = 0; i < 256; i++) m_dmem[i] = $urandom;
    for (int i = 0; i < 256; i++) m_imem[i] = 32'd0;

    m_imem[0]  = enc_r(8, 9, 10, F_ADD);
    m_imem[1]  = enc_r(8, 9, 11, F_SUB);
    m_imem[2]  = enc_i(T_BEQ, 8, 9, 16'd2);
    for (int i = 3; i < 16; i++) m_imem[i] = enc_i(T_ADDI, 0, 14, 16'd99);
    m_imem[5]  = enc_i(T_SW, 0, 8, 16'd4);
    m_imem[6]  = enc_i(T_LW, 0, 12, 16'd4);
    m_imem[7]  = {T_J, 26'h10};
    m_imem[16] = enc_i(T_ADDI, 0, 0, 16'd5);
    m_imem[17] = enc_r(8, 9, 13, F_SLT);
    m_imem[18] = enc_i(T_BEQ, 8, 10, 16'd5);
    m_imem[19] = enc_i(T_ADDI, 0, 8, 16'hFFFF);
    m_imem[20] = enc_r(8, 9, 13, F_SLT);
    for (int w = 21; w < 200; w++) begin
      logic [4:0] rs, rt, rd;
      logic [5:0] fn;
      rs = 5'($urandom_range(0, 31)); rt = 5'($urandom_range(0, 31));
      rd = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 4))
        0: fn = F_ADD;
        1: fn = F_SUB;
        2: fn = F_AND;
        3: fn = F_OR;
        default: fn = F_SLT;
      endcase
      case ($urandom_range(0, 10))
        0, 1, 2, 3: m_imem[w] = enc_r(rs, rt, rd, fn);
        4:          m_imem[w] = enc_r(rs, rt, rd, F_XOR);
        5, 6:       m_imem[w] = enc_i(T_ADDI, rs, rt, 16'($urandom));
        7:          m_imem[w] = enc_i(T_LW, 0, rt, 16'($urandom_range(0, 63) * 4));
        8:          m_imem[w] = enc_i(T_SW, 0, rt, 16'($urandom_range(0, 63) * 4));
        9:          m_imem[w] = enc_i(T_BEQ, rs, ($urandom_range(0, 1) != 0) ? rs : rt,
                                      16'($urandom_range(0, 3)));
        default:    m_imem[w] = enc_i(T_ORI, rs, rt, 16'($urandom));
      endcase
    end

    for (int i = 0; i < 32; i++)  dut.REG_FILE.memr[i]  = m_reg[i];
    for (int i = 0; i < 256; i++) dut.DATA_MEM.memd[i]  = m_dmem[i];
    for (int i = 0; i < 256; i++) dut.INSTR_MEM.memi[i] = m_imem[i];

    pc = 32'd0;
    for (int i = 0; i < NCYC; i++) begin
      model_step(pc, e);
      exp_q.push_back(e);
    end

    repeat (2) @(posedge Clk);
    #1;
    check("reset_pc", PcOut, 32'd0);
    check("reset_alu_result", AluResult, 32'd14);

    @(posedge Clk);
    #1 Rst = 1'b1;

    for (int i = 0; i < NCYC + 20; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge Clk);
    end
    check("drain_remaining", exp_q.size(), 32'd0);

    // Mid-cycle reset: PC clears at once, nothing already written is undone.
    #2 Rst = 1'b0;
    #1;
    cur_pc = 32'd0;
    check("midrun_reset_pc", PcOut, 32'd0);
    for (int i = 0; i < 32; i++)  check($sformatf("reg[%0d]", i), dut.REG_FILE.memr[i], m_reg[i]);
    for (int i = 0; i < 256; i++) check($sformatf("dmem[%0d]", i), dut.DATA_MEM.memd[i], m_dmem[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_single_cycle_core.md
Name: mips_single_cycle_core

Overview:
- Single-cycle 32-bit MIPS processor core; every instruction fetches, decodes, executes, accesses memory and writes back in one clock.
- Contains the PC register, instruction memory, register file, main/ALU control, ALU, data memory, branch and jump logic.
- Top-level processor of the design.
- Exposes key datapath values as outputs for debug/monitoring.

Parameters:
- IMEM_WORDS, 256, instruction memory depth in 32-bit words.
- DMEM_WORDS, 256, data memory depth in 32-bit words.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Rst  input  1  asynchronous, active-low reset.
- AluResult  output  32  ALU result of the current instruction.
- WriteData  output  32  value presented to the register-file write port (ALU result or memory read data).
- ReadData  output  32  data memory read data at the ALU-result address.
- WriteReg  output  5  destination register index: rd if RegDst=1, else rt.
- PcOut  output  32  current PC.

Behaviour:
- Reset:
  - Rst=0 asynchronously forces PC=0.
  - All outputs are combinational from PC and state, so after reset they reflect the instruction at address 0.
  - Memories and register file are NOT cleared by reset, so preloaded contents survive.
- Storage must be accessible by hierarchical path for bench preload:
  - instance INSTR_MEM, array memi [0:IMEM_WORDS-1][31:0], read-only, word index PC[31:2], combinational read.
  - instance DATA_MEM, array memd [0:DMEM_WORDS-1][31:0], word index AluResult[31:2], combinational read, synchronous write when MemWr.
  - instance REG_FILE, array memr [0:31][31:0], two combinational read ports, synchronous write when RegWr.
- Register $0 always reads 0; writes to $0 are ignored.
- Internal nets must be named InstrOut, RegDst, RegWr, AluSrc, AluCtrl (4-bit), Zero, PcSrc, Jump.
- Supported instructions (others behave as NOP: no register write, no memory write, PC+4):
  - R-type add, sub, and, or, slt.
  - lw, sw, beq, addi, j.
- ALU:
  - 32-bit; AluCtrl encoding 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1 or 0).
  - Overflow ignored, no exceptions.
  - Zero=1 when the result equals 0.
- Immediate is sign-extended to 32 bits; AluSrc selects the immediate for lw, sw, addi.
- Next PC:
  - PcSrc = Branch AND Zero.
  - Branch target = PC+4 + (signext(imm)<<2).
  - Jump target = {PC+4[31:28], instr[25:0], 2'b00}; Jump has priority over branch.
  - Default PC+4, 32-bit wrap.
- lw writes memory data (MemToReg); all other register-writing instructions write AluResult.
- sw writes rt to memory.
- Simultaneous events:
  - Register read-after-write in the same cycle reads the old value; the write lands at the clock edge.
  - Reset asserted mid-instruction suppresses nothing already written but returns PC to 0 immediately.

Decomposition:
- Shared package:
  - opcode constants (R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010).
  - funct constants (add 100000, sub 100010, and 100100, or 100101, slt 101010).
  - 4-bit ALU control codes.
- Natural sub-module: mips_reg_file (2R/1W, $0 hardwired).
- Memories and control are separate instances so the hierarchical names above hold.

Test Plan:
- Reset: Rst=0 -> PcOut=0; after release PC advances 0,4,8 each clock.
- With memr[8]=memr[9]=7:
  - add $10,$8,$9 -> AluResult=14, WriteReg=10, WriteData=14, RegWr=1, RegDst=1.
  - sub $11,$8,$9 -> AluResult=0, Zero=1.
- beq $8,$9,+2 at PC=8 -> PcSrc=1, next PcOut=20.
  - Same instruction with unequal registers -> next PcOut=12.
- sw $8,4($0) then lw $12,4($0):
  - memd[1]=7; lw gives ReadData=7, WriteData=7, WriteReg=12, AluSrc=1.
- j 0x10 -> Jump=1, next PcOut=64, no register or memory write.
- addi $0,$0,5 -> memr[0] still reads 0.
- slt $13,$8,$9 -> AluResult=0.
- slt with memr[8]=-1, memr[9]=7 -> AluResult=1.
